bank_wb_ctrl: RTL and testbench



---
 rtl/bank_wb_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_bank_wb_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_wb_ctrl.sv
// bank_wb_ctrl: per-bank write-back controller.
// Accepts one dirty-line eviction from htu, issues a single-beat 32-byte AXI3
// write (AW + one 256-bit W beat assembled from two 128-bit SRAM halves),
// waits for B and pulses completion back to htu.
// Optional feature macro: BANK_WBC_BRESP_CHK_EN -- when defined, a non-OKAY
// bresp or an unexpected bid raises wbc_htu_err_o alongside done; when
// undefined, bresp/bid are ignored and wbc_htu_err_o is tied low.
module bank_wb_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  htu_wbc_req_valid_i,
  output logic                  htu_wbc_req_ready_o,
  input  logic [ADDR_WIDTH-6:0] htu_wbc_req_addr_i,
  input  logic [5:0]            htu_wbc_req_set_way_i,
  input  logic                  sc_wbc_valid_i,
  output logic                  sc_wbc_ready_o,
  input  logic [127:0]          sc_wbc_data_i,
  input  logic                  sc_wbc_offset_i,
  output logic                  wbc_axi3_awvalid_o,
  input  logic                  wbc_axi3_awready_i,
  output logic [ID_WIDTH-1:0]   wbc_axi3_awid_o,
  output logic [ADDR_WIDTH-1:0] wbc_axi3_awaddr_o,
  output logic [3:0]            wbc_axi3_awlen_o,
  output logic [2:0]            wbc_axi3_awsize_o,
  output logic [1:0]            wbc_axi3_awburst_o,
  output logic                  wbc_axi3_wvalid_o,
  input  logic                  wbc_axi3_wready_i,
  output logic [ID_WIDTH-1:0]   wbc_axi3_wid_o,
  output logic [DATA_WIDTH-1:0] wbc_axi3_wdata_o,
  output logic [31:0]           wbc_axi3_wstrb_o,
  output logic                  wbc_axi3_wlast_o,
  input  logic                  wbc_axi3_bvalid_i,
  output logic                  wbc_axi3_bready_o,
  input  logic [ID_WIDTH-1:0]   wbc_axi3_bid_i,
  input  logic [1:0]            wbc_axi3_bresp_i,
  output logic                  wbc_htu_done_o,
  output logic [5:0]            wbc_htu_done_set_way_o,
  output logic                  wbc_htu_err_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WDATA, BRESP} state_e;

  state_e                state_q;
  logic                  req_ready_q;
  logic [ADDR_WIDTH-6:0] addr_q;
  logic [5:0]            set_way_q;
  logic                  awvalid_q;
  logic                  aw_done_q;
  logic                  aw_done_d;
  logic [1:0]            half_vld_q;
  logic [1:0]            half_vld_d;
  logic [127:0]          lo_q;
  logic [127:0]          hi_q;
  logic                  wvalid_q;
  logic                  bready_q;
  logic                  done_q;
  logic [5:0]            done_sw_q;
  logic                  aw_hs;
  logic                  sc_acc;
  logic [ID_WIDTH-1:0]   id_w;

  // AXI ID is the victim set/way, zero-extended
  assign id_w = {{(ID_WIDTH-6){1'b0}}, set_way_q};

  // A half already held stalls its beat instead of being overwritten
  assign sc_wbc_ready_o = (state_q == ISSUE) && !half_vld_q[sc_wbc_offset_i];
  assign sc_acc         = sc_wbc_valid_i & sc_wbc_ready_o;
  assign half_vld_d     = half_vld_q | (2'(sc_acc) << sc_wbc_offset_i);
  assign aw_hs          = awvalid_q & wbc_axi3_awready_i;
  assign aw_done_d      = aw_done_q | aw_hs;

  assign htu_wbc_req_ready_o    = req_ready_q;
  assign wbc_axi3_awvalid_o     = awvalid_q;
  assign wbc_axi3_awid_o        = id_w;
  assign wbc_axi3_awaddr_o      = {addr_q, 5'b0};
  assign wbc_axi3_awlen_o       = 4'd0;
  assign wbc_axi3_awsize_o      = 3'b101;
  assign wbc_axi3_awburst_o     = 2'b01;
  assign wbc_axi3_wvalid_o      = wvalid_q;
  assign wbc_axi3_wid_o         = id_w;
  assign wbc_axi3_wdata_o       = {hi_q, lo_q};
  assign wbc_axi3_wstrb_o       = '1;
  assign wbc_axi3_wlast_o       = wvalid_q;
  assign wbc_axi3_bready_o      = bready_q;
  assign wbc_htu_done_o         = done_q;
  assign wbc_htu_done_set_way_o = done_sw_q;

`ifdef BANK_WBC_BRESP_CHK_EN
  logic err_q;
  logic err_d;

  assign err_d         = (wbc_axi3_bresp_i != 2'b00) || (wbc_axi3_bid_i != id_w);
  assign wbc_htu_err_o = err_q;

  // Error flag captured with the completion pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (state_q == BRESP && wbc_axi3_bvalid_i) begin
      err_q <= err_d;
    end
  end
`else
  logic unused_bchk;

  assign unused_bchk   = ^{wbc_axi3_bresp_i, wbc_axi3_bid_i};
  assign wbc_htu_err_o = 1'b0;
`endif

  // Eviction sequencer: IDLE -> ISSUE (AW + fill) -> WDATA -> BRESP -> IDLE
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      addr_q      <= '0;
      set_way_q   <= '0;
      awvalid_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      half_vld_q  <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      done_q      <= 1'b0;
      done_sw_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (htu_wbc_req_valid_i && req_ready_q) begin
            addr_q      <= htu_wbc_req_addr_i;
            set_way_q   <= htu_wbc_req_set_way_i;
            aw_done_q   <= 1'b0;
            half_vld_q  <= '0;
            awvalid_q   <= 1'b1;
            req_ready_q <= 1'b0;
            state_q     <= ISSUE;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ISSUE: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
          end
          aw_done_q  <= aw_done_d;
          half_vld_q <= half_vld_d;
          if (sc_acc) begin
            if (sc_wbc_offset_i) begin
              hi_q <= sc_wbc_data_i;
            end else begin
              lo_q <= sc_wbc_data_i;
            end
          end
          if (aw_done_d && (&half_vld_d)) begin
            wvalid_q <= 1'b1;
            state_q  <= WDATA;
          end
        end
        WDATA: begin
          if (wbc_axi3_wready_i) begin
            wvalid_q <= 1'b0;
            bready_q <= 1'b1;
            state_q  <= BRESP;
          end
        end
        BRESP: begin
          if (wbc_axi3_bvalid_i) begin
            bready_q    <= 1'b0;
            done_q      <= 1'b1;
            done_sw_q   <= set_way_q;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bank_wb_ctrl.sv
// Directed testbench for bank_wb_ctrl. Builds with or without
// BANK_WBC_BRESP_CHK_EN; the expected error flag follows the macro.
module tb_bank_wb_ctrl;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [26:0]  req_addr;
  logic [5:0]   req_sw;
  logic         sc_valid;
  logic         sc_ready;
  logic [127:0] sc_data;
  logic         sc_off;
  logic         awvalid;
  logic         awready;
  logic [7:0]   awid;
  logic [31:0]  awaddr;
  logic [3:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         wvalid;
  logic         wready;
  logic [7:0]   wid;
  logic [255:0] wdata;
  logic [31:0]  wstrb;
  logic         wlast;
  logic         bvalid;
  logic         bready;
  logic [7:0]   bid;
  logic [1:0]   bresp;
  logic         done;
  logic [5:0]   done_sw;
  logic         err;

  int checks   = 0;
  int failures = 0;
  int aw_hs    = 0;
  logic exp_err_bad;

  bank_wb_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(256), .ID_WIDTH(8)) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .htu_wbc_req_valid_i    (req_valid),
    .htu_wbc_req_ready_o    (req_ready),
    .htu_wbc_req_addr_i     (req_addr),
    .htu_wbc_req_set_way_i  (req_sw),
    .sc_wbc_valid_i         (sc_valid),
    .sc_wbc_ready_o         (sc_ready),
    .sc_wbc_data_i          (sc_data),
    .sc_wbc_offset_i        (sc_off),
    .wbc_axi3_awvalid_o     (awvalid),
    .wbc_axi3_awready_i     (awready),
    .wbc_axi3_awid_o        (awid),
    .wbc_axi3_awaddr_o      (awaddr),
    .wbc_axi3_awlen_o       (awlen),
    .wbc_axi3_awsize_o      (awsize),
    .wbc_axi3_awburst_o     (awburst),
    .wbc_axi3_wvalid_o      (wvalid),
    .wbc_axi3_wready_i      (wready),
    .wbc_axi3_wid_o         (wid),
    .wbc_axi3_wdata_o       (wdata),
    .wbc_axi3_wstrb_o       (wstrb),
    .wbc_axi3_wlast_o       (wlast),
    .wbc_axi3_bvalid_i      (bvalid),
    .wbc_axi3_bready_o      (bready),
    .wbc_axi3_bid_i         (bid),
    .wbc_axi3_bresp_i       (bresp),
    .wbc_htu_done_o         (done),
    .wbc_htu_done_set_way_o (done_sw),
    .wbc_htu_err_o          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count AW handshakes seen on the bus
  always @(posedge clk) begin
    if (!rst && awvalid && awready) aw_hs <= aw_hs + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
    checks++; if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b0) begin failures++; $display("FAIL rst_valids got aw=%b w=%b b=%b exp=0", awvalid, wvalid, bready); end
    checks++; if (done !== 1'b0 || err !== 1'b0 || sc_ready !== 1'b0) begin failures++; $display("FAIL rst_done_err got done=%b err=%b scr=%b exp=0", done, err, sc_ready); end
    checks++; if (wdata !== 256'h0 || awid !== 8'h0 || awaddr !== 32'h0) begin failures++; $display("FAIL rst_data got awid=%h awaddr=%h exp=0", awid, awaddr); end
    rst = 1'b0;
    tick();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_basic();
    logic [127:0] lo = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    logic [127:0] hi = 128'h1f1e1d1c_1b1a1918_17161514_13121110;
    req_valid = 1'b1; req_addr = 27'h92; req_sw = 6'h15;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00; bid = 8'h00;
    tick();
    req_valid = 1'b0; sc_valid = 1'b1; sc_off = 1'b0; sc_data = lo;
    #1;
    checks++; if (awvalid !== 1'b1) begin failures++; $display("FAIL basic_awvalid got=%b exp=1", awvalid); end
    checks++; if (awaddr !== 32'h0000_1240) begin failures++; $display("FAIL basic_awaddr got=%h exp=00001240", awaddr); end
    checks++; if (awid !== 8'h15) begin failures++; $display("FAIL basic_awid got=%h exp=15", awid); end
    checks++; if (awlen !== 4'd0 || awsize !== 3'b101 || awburst !== 2'b01) begin failures++; $display("FAIL basic_awattr got len=%h size=%b burst=%b exp 0/101/01", awlen, awsize, awburst); end
    checks++; if (sc_ready !== 1'b1 || req_ready !== 1'b0) begin failures++; $display("FAIL basic_ready got scr=%b reqr=%b exp 1/0", sc_ready, req_ready); end
    tick();
    sc_off = 1'b1; sc_data = hi;
    #1;
    checks++; if (awvalid !== 1'b0 || sc_ready !== 1'b1 || wvalid !== 1'b0) begin failures++; $display("FAIL basic_t2 got aw=%b scr=%b w=%b exp 0/1/0", awvalid, sc_ready, wvalid); end
    tick();
    sc_valid = 1'b0;
    #1;
    checks++; if (wvalid !== 1'b1 || wlast !== 1'b1) begin failures++; $display("FAIL basic_wvalid got w=%b last=%b exp 1/1", wvalid, wlast); end
    checks++; if (wdata !== {hi, lo}) begin failures++; $display("FAIL basic_wdata got=%h exp=%h", wdata, {hi, lo}); end
    checks++; if (wid !== 8'h15 || wstrb !== 32'hffff_ffff) begin failures++; $display("FAIL basic_wid_strb got wid=%h strb=%h exp 15/ffffffff", wid, wstrb); end
    tick();
    checks++; if (wvalid !== 1'b0 || bready !== 1'b1) begin failures++; $display("FAIL basic_bready got w=%b b=%b exp 0/1", wvalid, bready); end
    bvalid = 1'b1; bid = 8'h15;
    tick();
    bvalid = 1'b0;
    checks++; if (done !== 1'b1 || done_sw !== 6'h15 || err !== 1'b0) begin failures++; $display("FAIL basic_done got done=%b sw=%h err=%b exp 1/15/0", done, done_sw, err); end
    checks++; if (req_ready !== 1'b1 || bready !== 1'b0) begin failures++; $display("FAIL basic_idle got reqr=%b bready=%b exp 1/0", req_ready, bready); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_reorder();
    logic [127:0] lo = 128'haaaa_0000_aaaa_0000_aaaa_0000_aaaa_0001;
    logic [127:0] hi = 128'hbbbb_1111_bbbb_1111_bbbb_1111_bbbb_1112;
    req_valid = 1'b1; req_addr = 27'h0123456; req_sw = 6'h2a;
    tick();
    req_valid = 1'b0; sc_valid = 1'b1; sc_off = 1'b1; sc_data = hi;
    #1;
    checks++; if (sc_ready !== 1'b1) begin failures++; $display("FAIL reord_first_hi got=%b exp=1", sc_ready); end
    tick();
    sc_data = 128'hdead_beef_dead_beef_dead_beef_dead_beef;
    #1;
    checks++; if (sc_ready !== 1'b0) begin failures++; $display("FAIL reord_dup_stall got=%b exp=0", sc_ready); end
    tick();
    checks++; if (sc_ready !== 1'b0 || wvalid !== 1'b0) begin failures++; $display("FAIL reord_dup_stall2 got scr=%b w=%b exp 0/0", sc_ready, wvalid); end
    sc_off = 1'b0; sc_data = lo;
    #1;
    checks++; if (sc_ready !== 1'b1) begin failures++; $display("FAIL reord_lo_ready got=%b exp=1", sc_ready); end
    tick();
    sc_valid = 1'b0;
    checks++; if (wvalid !== 1'b1 || wdata !== {hi, lo}) begin failures++; $display("FAIL reord_wdata got w=%b data=%h exp=%h", wvalid, wdata, {hi, lo}); end
    tick();
    bvalid = 1'b1; bid = 8'h2a;
    tick();
    bvalid = 1'b0;
    checks++; if (done !== 1'b1 || done_sw !== 6'h2a) begin failures++; $display("FAIL reord_done got done=%b sw=%h exp 1/2a", done, done_sw); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [127:0] lo = 128'h1234_5678_9abc_def0_1234_5678_9abc_def0;
    logic [127:0] hi = 128'hfedc_ba98_7654_3210_fedc_ba98_7654_3210;
    req_valid = 1'b1; req_addr = 27'h100; req_sw = 6'h3f;
    awready = 1'b0; wready = 1'b0;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin sc_valid = 1'b1; sc_off = 1'b0; sc_data = lo; end
      else if (i == 1) begin sc_valid = 1'b1; sc_off = 1'b1; sc_data = hi; end
      else sc_valid = 1'b0;
      #1;
      checks++; if (awvalid !== 1'b1 || awaddr !== 32'h0000_2000 || awid !== 8'h3f) begin failures++; $display("FAIL bp_aw_stable[%0d] got v=%b a=%h id=%h exp 1/00002000/3f", i, awvalid, awaddr, awid); end
      if (i < 2) begin
        checks++; if (sc_ready !== 1'b1) begin failures++; $display("FAIL bp_beat_accept[%0d] got=%b exp=1", i, sc_ready); end
      end
      checks++; if (wvalid !== 1'b0) begin failures++; $display("FAIL bp_no_w[%0d] got=%b exp=0", i, wvalid); end
      tick();
    end
    sc_valid = 1'b0; awready = 1'b1;
    #1;
    checks++; if (awvalid !== 1'b1) begin failures++; $display("FAIL bp_aw_last got=%b exp=1", awvalid); end
    tick();
    awready = 1'b0;
    checks++; if (awvalid !== 1'b0) begin failures++; $display("FAIL bp_aw_drop got=%b exp=0", awvalid); end
    for (int j = 0; j < 3; j++) begin
      checks++; if (wvalid !== 1'b1 || wlast !== 1'b1 || wdata !== {hi, lo} || wid !== 8'h3f) begin failures++; $display("FAIL bp_w_stable[%0d] got v=%b id=%h data=%h", j, wvalid, wid, wdata); end
      tick();
    end
    wready = 1'b1;
    #1;
    checks++; if (wvalid !== 1'b1 || wdata !== {hi, lo}) begin failures++; $display("FAIL bp_w_final got v=%b data=%h", wvalid, wdata); end
    tick();
    wready = 1'b0;
    checks++; if (wvalid !== 1'b0 || bready !== 1'b1) begin failures++; $display("FAIL bp_bready got w=%b b=%b exp 0/1", wvalid, bready); end
    bvalid = 1'b1; bid = 8'h3f;
    tick();
    bvalid = 1'b0; awready = 1'b1; wready = 1'b1;
    checks++; if (done !== 1'b1 || done_sw !== 6'h3f || err !== 1'b0) begin failures++; $display("FAIL bp_done got done=%b sw=%h err=%b exp 1/3f/0", done, done_sw, err); end
    tick();
  endtask

  task automatic test_err();
    req_valid = 1'b1; req_addr = 27'h7; req_sw = 6'h09;
    tick();
    req_valid = 1'b0; sc_valid = 1'b1; sc_off = 1'b0; sc_data = 128'h1;
    tick();
    sc_off = 1'b1; sc_data = 128'h2;
    tick();
    sc_valid = 1'b0;
    checks++; if (wvalid !== 1'b1 || wdata !== {128'h2, 128'h1}) begin failures++; $display("FAIL err_wdata got v=%b data=%h", wvalid, wdata); end
    tick();
    bvalid = 1'b1; bid = 8'h09; bresp = 2'b10;
    tick();
    bvalid = 1'b0; bresp = 2'b00;
    checks++; if (done !== 1'b1 || done_sw !== 6'h09) begin failures++; $display("FAIL err_done got done=%b sw=%h exp 1/09", done, done_sw); end
    checks++; if (err !== exp_err_bad) begin failures++; $display("FAIL err_flag got=%b exp=%b", err, exp_err_bad); end
    tick();
  endtask

  task automatic test_back_to_back();
    int hs0;
    hs0 = aw_hs;
    req_valid = 1'b1; req_addr = 27'h0a0; req_sw = 6'h01;
    tick();
    req_addr = 27'h0b0; req_sw = 6'h02;
    sc_valid = 1'b1; sc_off = 1'b0; sc_data = 128'h11;
    #1;
    checks++; if (req_ready !== 1'b0 || awaddr !== 32'h0000_1400) begin failures++; $display("FAIL b2b_first got reqr=%b addr=%h exp 0/00001400", req_ready, awaddr); end
    tick();
    sc_off = 1'b1; sc_data = 128'h22;
    tick();
    sc_valid = 1'b0;
    checks++; if (req_ready !== 1'b0 || wvalid !== 1'b1) begin failures++; $display("FAIL b2b_hold got reqr=%b w=%b exp 0/1", req_ready, wvalid); end
    tick();
    bvalid = 1'b1; bid = 8'h01;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL b2b_hold_b got=%b exp=0", req_ready); end
    tick();
    bvalid = 1'b0;
    checks++; if (done !== 1'b1 || done_sw !== 6'h01 || req_ready !== 1'b1) begin failures++; $display("FAIL b2b_done1 got done=%b sw=%h reqr=%b exp 1/01/1", done, done_sw, req_ready); end
    tick();
    req_valid = 1'b0;
    checks++; if (awvalid !== 1'b1 || awaddr !== 32'h0000_1600 || awid !== 8'h02 || req_ready !== 1'b0) begin failures++; $display("FAIL b2b_second_aw got v=%b a=%h id=%h r=%b", awvalid, awaddr, awid, req_ready); end
    sc_valid = 1'b1; sc_off = 1'b0; sc_data = 128'h33;
    tick();
    sc_off = 1'b1; sc_data = 128'h44;
    tick();
    sc_valid = 1'b0;
    checks++; if (wvalid !== 1'b1 || wdata !== {128'h44, 128'h33} || wid !== 8'h02) begin failures++; $display("FAIL b2b_w2 got v=%b id=%h data=%h", wvalid, wid, wdata); end
    tick();
    bvalid = 1'b1; bid = 8'h02;
    tick();
    bvalid = 1'b0;
    checks++; if (done !== 1'b1 || done_sw !== 6'h02) begin failures++; $display("FAIL b2b_done2 got done=%b sw=%h exp 1/02", done, done_sw); end
    checks++; if (aw_hs - hs0 !== 2) begin failures++; $display("FAIL b2b_aw_count got=%0d exp=2", aw_hs - hs0); end
    tick();
  endtask

  task automatic test_midop_reset();
    req_valid = 1'b1; req_addr = 27'h55; req_sw = 6'h33; wready = 1'b0;
    tick();
    req_valid = 1'b0; sc_valid = 1'b1; sc_off = 1'b0; sc_data = 128'h5;
    tick();
    sc_off = 1'b1; sc_data = 128'h6;
    tick();
    sc_valid = 1'b0;
    checks++; if (wvalid !== 1'b1) begin failures++; $display("FAIL mid_wvalid got=%b exp=1", wvalid); end
    rst = 1'b1;
    tick();
    checks++; if (wvalid !== 1'b0 || done !== 1'b0 || awvalid !== 1'b0) begin failures++; $display("FAIL mid_abort got w=%b done=%b aw=%b exp 0/0/0", wvalid, done, awvalid); end
    rst = 1'b0;
    tick();
    checks++; if (req_ready !== 1'b1 || wvalid !== 1'b0 || bready !== 1'b0) begin failures++; $display("FAIL mid_idle got reqr=%b w=%b b=%b exp 1/0/0", req_ready, wvalid, bready); end
    wready = 1'b1;
  endtask

  initial begin
`ifdef BANK_WBC_BRESP_CHK_EN
    exp_err_bad = 1'b1;
`else
    exp_err_bad = 1'b0;
`endif
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_sw = '0;
    sc_valid = 1'b0; sc_data = '0; sc_off = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
    test_reset();
    test_basic();
    test_reorder();
    test_backpressure();
    test_err();
    test_back_to_back();
    test_midop_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
